hack_clock_ctrl: RTL and testbench

Run controller for the Hack CPU clock. It generates hack_clk from the system clock with a programmable half-period, and supports run, halt and single-step commands. It stretches the current hack_clk phase while external memory (SPI RAM/ROM) reports busy. It sits between the SoC control/debug interface and the Hack CPU, and replaces a free-running fixed divider.

---
 rtl/hack_clock_ctrl.sv | 154 +++++++++++++++
 tb/tb_hack_clock_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_clock_ctrl.sv
// hack_clock_ctrl: run/halt/single-step controller for the Hack CPU clock.
// hack_clk half-period is (div_reg + 1) clk cycles; the terminal count is
// stretched while mem_busy is high. hack_clk always stops low.
// Optional macro HACK_CLOCK_CYCLE_COUNT_EN enables the 16-bit rising-edge
// counter on cycle_count; otherwise cycle_count is tied to zero.
module hack_clock_ctrl #(
    parameter int unsigned DIV_WIDTH   = 6,
    parameter int unsigned DEFAULT_DIV = 18,
    parameter int unsigned AUTO_RUN    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_cmd,
    input  logic                 halt_cmd,
    input  logic                 step_cmd,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 mem_busy,
    output logic                 hack_clk,
    output logic                 strobe,
    output logic                 rise_strobe,
    output logic                 running,
    output logic [15:0]          cycle_count
);

    localparam logic [1:0] ST_HALTED  = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_STEP    = 2'd2;
    localparam logic [1:0] ST_RESET   = (AUTO_RUN != 0) ? ST_RUNNING : ST_HALTED;

    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic                 halt_pend_q, halt_pend_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] tc_q, tc_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 hack_clk_q, hack_clk_d;
    logic                 strobe_q, rise_q, running_q;

    logic                 active;
    logic                 at_tc;
    logic                 toggle;
    logic                 rise_evt;
    logic                 fall_evt;
    logic [DIV_WIDTH-1:0] div_clamped;

    assign active      = (state_q != ST_HALTED);
    assign at_tc       = (cnt_q == tc_q);
    assign toggle      = active && at_tc && !mem_busy;
    assign rise_evt    = toggle && !hack_clk_q;
    assign fall_evt    = toggle && hack_clk_q;
    assign div_clamped = (div_value == '0) ? DIV_MIN : div_value;

    // Divider register, terminal count and phase counter next-state.
    // tc_q snapshots the divider only at a reload point (or while halted),
    // so a div_load mid-phase never changes the phase in progress.
    always_comb begin
        div_d = div_load ? div_clamped : div_q;
        tc_d  = tc_q;
        cnt_d = cnt_q;
        if (!active || toggle) begin
            cnt_d = '0;
            tc_d  = div_d;
        end else if (!at_tc) begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
        hack_clk_d = toggle ? ~hack_clk_q : hack_clk_q;
    end

    // Run-state next-state; command priority is halt > step > run.
    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            ST_HALTED: begin
                halt_pend_d = 1'b0;
                if (!halt_cmd) begin
                    if (step_cmd)     state_d = ST_STEP;
                    else if (run_cmd) state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (halt_cmd) halt_pend_d = 1'b1;
                if (fall_evt && halt_pend_q) begin
                    state_d     = ST_HALTED;
                    halt_pend_d = 1'b0;
                end
            end
            ST_STEP: begin
                halt_pend_d = 1'b0;
                if (!halt_cmd && run_cmd) state_d = ST_RUNNING;
                else if (fall_evt)        state_d = ST_HALTED;
            end
            default: begin
                state_d     = ST_HALTED;
                halt_pend_d = 1'b0;
            end
        endcase
    end

    // Control and phase state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RESET;
            halt_pend_q <= 1'b0;
            div_q       <= DIV_RESET;
            tc_q        <= DIV_RESET;
            cnt_q       <= '0;
            hack_clk_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            div_q       <= div_d;
            tc_q        <= tc_d;
            cnt_q       <= cnt_d;
            hack_clk_q  <= hack_clk_d;
        end
    end

    // Registered status pulses; running follows the state one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q  <= 1'b0;
            rise_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            strobe_q  <= toggle;
            rise_q    <= rise_evt;
            running_q <= active;
        end
    end

`ifdef HACK_CLOCK_CYCLE_COUNT_EN
    logic [15:0] cc_q;

    // Rising-edge counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        cc_q <= '0;
        else if (rise_evt) cc_q <= cc_q + 16'd1;
    end

    assign cycle_count = cc_q;
`else
    assign cycle_count = 16'h0000;
`endif

    assign hack_clk    = hack_clk_q;
    assign strobe      = strobe_q;
    assign rise_strobe = rise_q;
    assign running     = running_q;

endmodule

// File: tb/tb_hack_clock_ctrl.sv
// Directed testbench for hack_clock_ctrl (DIV 18, AUTO_RUN 0 and 1 instances).
module tb_hack_clock_ctrl;

    logic       clk;
    logic       reset;
    logic       run_cmd, halt_cmd, step_cmd, div_load, mem_busy;
    logic [5:0] div_value;
    logic       hack_clk, strobe, rise_strobe, running;
    logic [15:0] cycle_count;
    logic       zero;
    logic [5:0] zero6;
    logic       a_hack_clk, a_strobe, a_rise, a_running;
    logic [15:0] a_cc;

    int checks = 0;
    int errors = 0;
    int exp_rises = 0;
    int strobe_cnt = 0;

    hack_clock_ctrl #(.DIV_WIDTH(6), .DEFAULT_DIV(18), .AUTO_RUN(0)) u_dut (
        .clk(clk), .reset(reset), .run_cmd(run_cmd), .halt_cmd(halt_cmd),
        .step_cmd(step_cmd), .div_load(div_load), .div_value(div_value),
        .mem_busy(mem_busy), .hack_clk(hack_clk), .strobe(strobe),
        .rise_strobe(rise_strobe), .running(running), .cycle_count(cycle_count)
    );

    hack_clock_ctrl #(.DIV_WIDTH(6), .DEFAULT_DIV(18), .AUTO_RUN(1)) u_auto (
        .clk(clk), .reset(reset), .run_cmd(zero), .halt_cmd(zero),
        .step_cmd(zero), .div_load(zero), .div_value(zero6),
        .mem_busy(zero), .hack_clk(a_hack_clk), .strobe(a_strobe),
        .rise_strobe(a_rise), .running(a_running), .cycle_count(a_cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (strobe === 1'b1) strobe_cnt++;

    initial begin
        #300000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] exp_cc(input int r);
`ifdef HACK_CLOCK_CYCLE_COUNT_EN
        return 16'(r);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_strobe(input int max, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (strobe !== 1'b1 && n <= max);
    endtask

    task automatic wait_strobe_auto(input int max, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (a_strobe !== 1'b1 && n <= max);
    endtask

    task automatic pulse_run();
        run_cmd = 1'b1; tick(1); run_cmd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++; if ({hack_clk, strobe, rise_strobe, running} !== 4'b0) begin errors++; $display("FAIL reset_outs got %b exp 0000", {hack_clk, strobe, rise_strobe, running}); end
        checks++; if (cycle_count !== 16'h0) begin errors++; $display("FAIL reset_cc got %0d exp 0", cycle_count); end
        checks++; if ({a_hack_clk, a_strobe, a_rise, a_running} !== 4'b0) begin errors++; $display("FAIL reset_auto_outs got %b exp 0000", {a_hack_clk, a_strobe, a_rise, a_running}); end
        checks++; if (a_cc !== 16'h0) begin errors++; $display("FAIL reset_auto_cc got %0d exp 0", a_cc); end
        reset = 1'b1;
    endtask

    task automatic test_auto_run();
        int n;
        for (int i = 0; i < 6; i++) begin
            wait_strobe_auto(100, n);
            checks++; if (n !== 19) begin errors++; $display("FAIL auto_period[%0d] got %0d exp 19", i, n); end
            checks++; if (a_rise !== ((i % 2) == 0)) begin errors++; $display("FAIL auto_rise[%0d] got %b exp %b", i, a_rise, (i % 2) == 0); end
            checks++; if (a_hack_clk !== ((i % 2) == 0)) begin errors++; $display("FAIL auto_hclk[%0d] got %b exp %b", i, a_hack_clk, (i % 2) == 0); end
            if (i == 0) begin
                checks++; if (a_running !== 1'b1) begin errors++; $display("FAIL auto_running got %b exp 1", a_running); end
            end
        end
        checks++; if (a_cc !== exp_cc(3)) begin errors++; $display("FAIL auto_cc got %0d exp %0d", a_cc, exp_cc(3)); end
        checks++; if (strobe_cnt !== 0 || hack_clk !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL halted_idle got strobes %0d hclk %b run %b exp 0 0 0", strobe_cnt, hack_clk, running); end
    endtask

    task automatic test_step();
        int n, s0;
        step_cmd = 1'b1; tick(1); step_cmd = 1'b0;
        wait_strobe(100, n);
        exp_rises++;
        checks++; if (n !== 19) begin errors++; $display("FAIL step_rise_time got %0d exp 19", n); end
        checks++; if (rise_strobe !== 1'b1 || hack_clk !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL step_rise got rs %b hclk %b run %b exp 1 1 1", rise_strobe, hack_clk, running); end
        wait_strobe(100, n);
        checks++; if (n !== 19) begin errors++; $display("FAIL step_fall_time got %0d exp 19", n); end
        checks++; if (rise_strobe !== 1'b0 || hack_clk !== 1'b0) begin errors++; $display("FAIL step_fall got rs %b hclk %b exp 0 0", rise_strobe, hack_clk); end
        tick(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_running_end got %b exp 0", running); end
        checks++; if (cycle_count !== exp_cc(exp_rises)) begin errors++; $display("FAIL step_cc got %0d exp %0d", cycle_count, exp_cc(exp_rises)); end
        s0 = strobe_cnt;
        tick(50);
        checks++; if (strobe_cnt !== s0 || hack_clk !== 1'b0) begin errors++; $display("FAIL step_stays_halted got strobes %0d hclk %b exp %0d 0", strobe_cnt, hack_clk, s0); end
    endtask

    task automatic test_step_run();
        int n;
        step_cmd = 1'b1; tick(1); step_cmd = 1'b0;
        wait_strobe(100, n);
        exp_rises++;
        tick(3);
        pulse_run();
        wait_strobe(100, n);
        checks++; if (n !== 15 || hack_clk !== 1'b0) begin errors++; $display("FAIL steprun_fall got t %0d hclk %b exp 15 0", n, hack_clk); end
        tick(1);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL steprun_running got %b exp 1", running); end
        wait_strobe(100, n);
        exp_rises++;
        checks++; if (n !== 18 || rise_strobe !== 1'b1) begin errors++; $display("FAIL steprun_rise got t %0d rs %b exp 18 1", n, rise_strobe); end
        halt_cmd = 1'b1; tick(1); halt_cmd = 1'b0;
        wait_strobe(100, n);
        checks++; if (n !== 18 || hack_clk !== 1'b0) begin errors++; $display("FAIL steprun_halt got t %0d hclk %b exp 18 0", n, hack_clk); end
        tick(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL steprun_halted got %b exp 0", running); end
    endtask

    task automatic test_halt();
        int n, s0;
        pulse_run();
        wait_strobe(100, n);
        exp_rises++;
        checks++; if (n !== 19 || rise_strobe !== 1'b1) begin errors++; $display("FAIL halt_first_rise got t %0d rs %b exp 19 1", n, rise_strobe); end
        tick(4);
        halt_cmd = 1'b1; tick(1); halt_cmd = 1'b0;
        wait_strobe(100, n);
        checks++; if (n !== 14 || hack_clk !== 1'b0) begin errors++; $display("FAIL halt_fall got t %0d hclk %b exp 14 0", n, hack_clk); end
        tick(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_running got %b exp 0", running); end
        s0 = strobe_cnt;
        tick(200);
        checks++; if (strobe_cnt !== s0 || hack_clk !== 1'b0) begin errors++; $display("FAIL halt_quiet got strobes %0d hclk %b exp %0d 0", strobe_cnt, hack_clk, s0); end
        checks++; if (cycle_count !== exp_cc(exp_rises)) begin errors++; $display("FAIL halt_cc got %0d exp %0d", cycle_count, exp_cc(exp_rises)); end
    endtask

    task automatic test_stretch();
        int n;
        bit held;
        pulse_run();
        wait_strobe(100, n);
        exp_rises++;
        tick(18);
        mem_busy = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (strobe !== 1'b0 || hack_clk !== 1'b1) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL stretch_hold got %b exp 1", held); end
        mem_busy = 1'b0;
        tick(1);
        checks++; if (strobe !== 1'b1 || hack_clk !== 1'b0) begin errors++; $display("FAIL stretch_toggle got strobe %b hclk %b exp 1 0", strobe, hack_clk); end
        halt_cmd = 1'b1; tick(1); halt_cmd = 1'b0;
        wait_strobe(100, n);
        exp_rises++;
        checks++; if (n !== 18 || rise_strobe !== 1'b1) begin errors++; $display("FAIL stretch_restart got t %0d rs %b exp 18 1", n, rise_strobe); end
        wait_strobe(100, n);
        checks++; if (n !== 19 || hack_clk !== 1'b0) begin errors++; $display("FAIL stretch_halt got t %0d hclk %b exp 19 0", n, hack_clk); end
        tick(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL stretch_halted got %b exp 0", running); end
    endtask

    task automatic test_div_load();
        int n;
        pulse_run();
        wait_strobe(100, n);
        exp_rises++;
        tick(5);
        div_value = 6'd0; div_load = 1'b1; tick(1); div_load = 1'b0;
        wait_strobe(100, n);
        checks++; if (n !== 13 || hack_clk !== 1'b0) begin errors++; $display("FAIL div_old_phase got t %0d hclk %b exp 13 0", n, hack_clk); end
        wait_strobe(100, n);
        exp_rises++;
        checks++; if (n !== 2 || rise_strobe !== 1'b1) begin errors++; $display("FAIL div_new_rise got t %0d rs %b exp 2 1", n, rise_strobe); end
        wait_strobe(100, n);
        checks++; if (n !== 2 || hack_clk !== 1'b0) begin errors++; $display("FAIL div_new_fall got t %0d hclk %b exp 2 0", n, hack_clk); end
        halt_cmd = 1'b1; tick(1); halt_cmd = 1'b0;
        wait_strobe(100, n);
        exp_rises++;
        checks++; if (n !== 1 || rise_strobe !== 1'b1) begin errors++; $display("FAIL div_halt_rise got t %0d rs %b exp 1 1", n, rise_strobe); end
        wait_strobe(100, n);
        checks++; if (n !== 2 || hack_clk !== 1'b0) begin errors++; $display("FAIL div_halt_fall got t %0d hclk %b exp 2 0", n, hack_clk); end
        div_value = 6'd18; div_load = 1'b1; tick(1); div_load = 1'b0;
        tick(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL div_halted got %b exp 0", running); end
        checks++; if (cycle_count !== exp_cc(exp_rises)) begin errors++; $display("FAIL div_cc got %0d exp %0d", cycle_count, exp_cc(exp_rises)); end
    endtask

    task automatic test_priority();
        int n, s0;
        pulse_run();
        wait_strobe(100, n);
        exp_rises++;
        checks++; if (n !== 19) begin errors++; $display("FAIL prio_rise got %0d exp 19", n); end
        tick(2);
        halt_cmd = 1'b1; step_cmd = 1'b1; run_cmd = 1'b1;
        tick(1);
        halt_cmd = 1'b0; step_cmd = 1'b0; run_cmd = 1'b0;
        wait_strobe(100, n);
        checks++; if (n !== 16 || hack_clk !== 1'b0) begin errors++; $display("FAIL prio_fall got t %0d hclk %b exp 16 0", n, hack_clk); end
        tick(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL prio_running got %b exp 0", running); end
        s0 = strobe_cnt;
        tick(40);
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL prio_quiet got %0d exp %0d", strobe_cnt, s0); end
    endtask

    task automatic test_reset_mid();
        int n, s0;
        pulse_run();
        wait_strobe(100, n);
        exp_rises++;
        tick(7);
        reset = 1'b0;
        #1;
        checks++; if ({hack_clk, strobe, rise_strobe, running} !== 4'b0) begin errors++; $display("FAIL rstmid_outs got %b exp 0000", {hack_clk, strobe, rise_strobe, running}); end
        checks++; if (cycle_count !== 16'h0) begin errors++; $display("FAIL rstmid_cc got %0d exp 0", cycle_count); end
        tick(2);
        reset = 1'b1;
        s0 = strobe_cnt;
        tick(40);
        checks++; if (strobe_cnt !== s0 || running !== 1'b0 || hack_clk !== 1'b0) begin errors++; $display("FAIL rstmid_halted got strobes %0d run %b hclk %b exp %0d 0 0", strobe_cnt, running, hack_clk, s0); end
    endtask

    initial begin
        reset = 1'b0;
        run_cmd = 1'b0; halt_cmd = 1'b0; step_cmd = 1'b0;
        div_load = 1'b0; div_value = 6'd0; mem_busy = 1'b0;
        zero = 1'b0; zero6 = 6'd0;
        test_reset();
        test_auto_run();
        test_step();
        test_step_run();
        test_halt();
        test_stretch();
        test_div_load();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
